// File: rtl/cache_line_fill.sv
// Line refill / writeback engine for the data cache.
// Accepts a miss, optionally writes the dirty victim back as four word writes,
// then fetches the new four-word line over the pipelined m0 master port and
// hands the assembled line back to the cache with a one-cycle done pulse.
module cache_line_fill #(
    parameter int unsigned SIZE      = 8*1024,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic         clk,
    input  logic         rest,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [27:0]  req_lineAddr,
    input  logic         req_dirty,
    input  logic [27:0]  req_victimAddr,
    input  logic [127:0] req_victimData,
    output logic         done,
    output logic [127:0] lineData,
    output logic [31:0]  m0_address,
    output logic [3:0]   m0_byteEnable,
    output logic         m0_read,
    output logic         m0_write,
    output logic [31:0]  m0_writeData,
    input  logic [31:0]  m0_readData,
    input  logic         m0_waitRequest,
    input  logic         m0_readDataValid
);

    typedef enum logic [1:0] {
        IDLE,
        WB,
        RD,
        DONE
    } fillState;

    localparam logic [2:0] MaxOut    = 3'(MAX_OUTST);
    localparam logic [2:0] LineWords = 3'd4;

    // SIZE only describes the surrounding cache; the line format is fixed.
    if (MAX_OUTST < 1 || MAX_OUTST > 4 || SIZE < 16) begin : gBadParams
        $error("cache_line_fill: MAX_OUTST must be 1..4 and SIZE at least one line");
    end

    fillState state;
    fillState stateNext;

    // Request fields latched on accept
    logic [27:0]  lineAddrQ;
    logic [27:0]  victimAddrQ;
    logic [127:0] victimDataQ;

    // Transfer counters
    logic [2:0] wbCount;
    logic [2:0] issued;
    logic [2:0] returned;

    // Handshake decodes
    logic accept;
    logic writeFire;
    logic readFire;
    logic beatFire;
    logic lastWrite;
    logic lastBeat;

    // Next values for the registered command outputs and counters
    logic [2:0]   wbCountNext;
    logic [2:0]   issuedNext;
    logic [2:0]   returnedNext;
    logic [2:0]   outstandingNext;
    logic         writeNext;
    logic         readNext;
    logic [31:0]  addressNext;
    logic [31:0]  writeDataNext;
    logic [27:0]  lineSel;
    logic [27:0]  victimSel;
    logic [127:0] victimDataSel;

    // Handshake decodes shared by the FSM and the datapath
    always_comb begin
        accept    = req_valid && req_ready;
        writeFire = m0_write && !m0_waitRequest;
        readFire  = m0_read && !m0_waitRequest;
        beatFire  = m0_readDataValid && (state == RD) && (returned < LineWords);
        lastWrite = writeFire && (wbCount == 3'd3);
        lastBeat  = beatFire && (returned == 3'd3);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rest) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    stateNext = req_dirty ? WB : RD;
                end
            end
            WB: begin
                if (lastWrite) begin
                    stateNext = RD;
                end
            end
            RD: begin
                if (lastBeat) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // FSM-decoded outputs
    always_comb begin
        req_ready     = (state == IDLE) && !rest;
        done          = (state == DONE);
        m0_byteEnable = (m0_read || m0_write) ? 4'hF : 4'h0;
    end

    // Command scheduling: decide what the registered m0 outputs present next cycle.
    // The request fields are taken straight from the inputs in the accept cycle so
    // the first command can appear the cycle after accept; later cycles use the
    // latched copy. A stalled command keeps its counter value, so address and data
    // recompute to the same values and stay stable.
    always_comb begin
        lineSel       = (state == IDLE) ? req_lineAddr   : lineAddrQ;
        victimSel     = (state == IDLE) ? req_victimAddr : victimAddrQ;
        victimDataSel = (state == IDLE) ? req_victimData : victimDataQ;

        wbCountNext  = accept ? 3'd0 : wbCount  + {2'b00, writeFire};
        issuedNext   = accept ? 3'd0 : issued   + {2'b00, readFire};
        returnedNext = accept ? 3'd0 : returned + {2'b00, beatFire};
        outstandingNext = issuedNext - returnedNext;

        writeNext = (stateNext == WB) && (wbCountNext < LineWords);
        readNext  = (stateNext == RD) && (issuedNext < LineWords)
                    && (outstandingNext < MaxOut);

        addressNext   = m0_address;
        writeDataNext = m0_writeData;
        if (writeNext) begin
            addressNext   = {victimSel, wbCountNext[1:0], 2'b00};
            writeDataNext = victimDataSel[{wbCountNext[1:0], 5'b00000} +: 32];
        end else if (readNext) begin
            addressNext = {lineSel, issuedNext[1:0], 2'b00};
        end
    end

    // Latch the request on accept; later input changes are ignored
    always_ff @(posedge clk) begin
        if (rest) begin
            lineAddrQ   <= '0;
            victimAddrQ <= '0;
            victimDataQ <= '0;
        end else if (accept) begin
            lineAddrQ   <= req_lineAddr;
            victimAddrQ <= req_victimAddr;
            victimDataQ <= req_victimData;
        end
    end

    // Registered command outputs and transfer counters
    always_ff @(posedge clk) begin
        if (rest) begin
            m0_read      <= 1'b0;
            m0_write     <= 1'b0;
            m0_address   <= '0;
            m0_writeData <= '0;
            wbCount      <= '0;
            issued       <= '0;
            returned     <= '0;
        end else begin
            m0_read      <= readNext;
            m0_write     <= writeNext;
            m0_address   <= addressNext;
            m0_writeData <= writeDataNext;
            wbCount      <= wbCountNext;
            issued       <= issuedNext;
            returned     <= returnedNext;
        end
    end

    // Assemble the returned beats in order; held until overwritten by the next fill
    always_ff @(posedge clk) begin
        if (rest) begin
            lineData <= '0;
        end else if (beatFire) begin
            lineData[{returned[1:0], 5'b00000} +: 32] <= m0_readData;
        end
    end

endmodule

// File: tb/tb_cache_line_fill.sv
// Self-checking bench for cache_line_fill: behavioural memory responder plus
// directed and randomized miss transactions checked against a line-level model.
module tb_cache_line_fill;

    localparam int unsigned MaxOut = 4;

    logic         clk = 1'b0;
    logic         rest;
    logic         req_valid;
    logic         req_ready;
    logic [27:0]  req_lineAddr;
    logic         req_dirty;
    logic [27:0]  req_victimAddr;
    logic [127:0] req_victimData;
    logic         done;
    logic [127:0] lineData;
    logic [31:0]  m0_address;
    logic [3:0]   m0_byteEnable;
    logic         m0_read;
    logic         m0_write;
    logic [31:0]  m0_writeData;
    logic [31:0]  m0_readData;
    logic         m0_waitRequest;
    logic         m0_readDataValid;

    always #5 clk = ~clk;

    cache_line_fill #(
        .SIZE      (8*1024),
        .MAX_OUTST (MaxOut)
    ) dut (
        .clk              (clk),
        .rest             (rest),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_lineAddr     (req_lineAddr),
        .req_dirty        (req_dirty),
        .req_victimAddr   (req_victimAddr),
        .req_victimData   (req_victimData),
        .done             (done),
        .lineData         (lineData),
        .m0_address       (m0_address),
        .m0_byteEnable    (m0_byteEnable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writeData     (m0_writeData),
        .m0_readData      (m0_readData),
        .m0_waitRequest   (m0_waitRequest),
        .m0_readDataValid (m0_readDataValid)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents and responder configuration
    logic [31:0] memInit [logic [31:0]];
    logic [31:0] memSalt = 32'h0;
    int          latency = 1;
    int          stallPct = 0;
    int          stallOnRead = -1;
    int          stallLeft = 0;
    logic        strayBeat = 1'b0;
    int          expWrites = 0;

    // Observations collected by the responder
    logic [31:0] wrAddrLog [$];
    logic [31:0] wrDataLog [$];
    logic [31:0] rdAddrLog [$];
    logic [31:0] retDataQ  [$];
    int          retDueQ   [$];
    int          rdAcceptCount = 0;
    int          retDriven = 0;
    int          outst = 0;
    int          maxOutst = 0;
    int          presentedAt1234 = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dataAt(input logic [31:0] a);
        if (memInit.exists(a)) return memInit[a];
        return (a * 32'h9E37_79B1) ^ memSalt;
    endfunction

    // Memory responder: acts 1 time unit after each falling edge, deciding stall and
    // read-return for the following rising edge.
    initial begin
        int          due;
        int          lastDue;
        logic        stall;
        logic        prevStall;
        logic [69:0] prevCmd;
        lastDue          = 0;
        prevStall        = 1'b0;
        prevCmd          = '0;
        m0_waitRequest   = 1'b0;
        m0_readDataValid = 1'b0;
        m0_readData      = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rest) begin
                retDataQ.delete();
                retDueQ.delete();
                lastDue          = 0;
                outst            = 0;
                prevStall        = 1'b0;
                m0_waitRequest   = 1'b0;
                m0_readDataValid = 1'b0;
                continue;
            end
            if (prevStall) begin
                check("stall_hold", {m0_read, m0_write, m0_address, m0_writeData},
                      prevCmd);
            end
            // read data return
            if (retDueQ.size() > 0 && retDueQ[0] <= cyc) begin
                m0_readDataValid = 1'b1;
                m0_readData      = retDataQ.pop_front();
                void'(retDueQ.pop_front());
                outst--;
                retDriven++;
            end else if (strayBeat) begin
                m0_readDataValid = 1'b1;
                m0_readData      = 32'hDEAD_BEEF;
                strayBeat        = 1'b0;
            end else begin
                m0_readDataValid = 1'b0;
            end
            // command acceptance
            if (m0_read && m0_address == 32'h0000_1234) presentedAt1234++;
            stall = 1'b0;
            if (m0_read || m0_write) begin
                check("byte_enable", m0_byteEnable, 4'hF);
                if (m0_read && stallLeft > 0 && rdAcceptCount == stallOnRead) begin
                    stall = 1'b1;
                    stallLeft--;
                end else if ($urandom_range(99) < stallPct) begin
                    stall = 1'b1;
                end
            end else begin
                check("byte_enable_idle", m0_byteEnable, 4'h0);
            end
            m0_waitRequest = stall;
            if ((m0_read || m0_write) && !stall) begin
                if (m0_write) begin
                    wrAddrLog.push_back(m0_address);
                    wrDataLog.push_back(m0_writeData);
                end
                if (m0_read) begin
                    check("writes_before_read", wrAddrLog.size(), expWrites);
                    rdAddrLog.push_back(m0_address);
                    rdAcceptCount++;
                    due = cyc + latency;
                    if (due <= lastDue) due = lastDue + 1;
                    lastDue = due;
                    retDueQ.push_back(due);
                    retDataQ.push_back(dataAt(m0_address));
                    outst++;
                    if (outst > maxOutst) maxOutst = outst;
                    check("outstanding_limit", (outst <= int'(MaxOut)), 1'b1);
                end
            end
            prevStall = (m0_read || m0_write) && stall;
            prevCmd   = {m0_read, m0_write, m0_address, m0_writeData};
        end
    end

    task automatic startMiss(input logic [27:0] la, input logic dirty, input logic [27:0] va,
                             input logic [127:0] vd, output int t0);
        wrAddrLog.delete();
        wrDataLog.delete();
        rdAddrLog.delete();
        rdAcceptCount   = 0;
        retDriven       = 0;
        maxOutst        = 0;
        presentedAt1234 = 0;
        expWrites       = dirty ? 4 : 0;
        req_valid       = 1'b1;
        req_lineAddr    = la;
        req_dirty       = dirty;
        req_victimAddr  = va;
        req_victimData  = vd;
        #1;
        check("req_ready_idle", req_ready, 1'b1);
        t0 = cyc;
    endtask

    task automatic scrambleReq();
        req_lineAddr   = 28'($urandom);
        req_dirty      = 1'($urandom);
        req_victimAddr = 28'($urandom);
        req_victimData = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic finishMiss(input logic [27:0] la, input logic dirty, input logic [27:0] va,
                              input logic [127:0] vd, input int t0, input int expLat,
                              input logic holdValid);
        logic [127:0] expLine;
        int n;
        @(negedge clk);
        if (!holdValid) req_valid = 1'b0;
        scrambleReq();
        n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            if (holdValid) scrambleReq();
            n++;
        end
        req_valid = 1'b0;
        check("done_seen", done, 1'b1);
        if (expLat >= 0) check("done_latency", cyc - t0, expLat);
        for (int i = 0; i < 4; i++) expLine[32*i +: 32] = dataAt({la, i[1:0], 2'b00});
        check("line_data", lineData, expLine);
        check("write_count", wrAddrLog.size(), dirty ? 4 : 0);
        for (int i = 0; i < 4 && i < wrAddrLog.size(); i++) begin
            check("write_addr", wrAddrLog[i], {va, i[1:0], 2'b00});
            check("write_data", wrDataLog[i], vd[32*i +: 32]);
        end
        check("read_count", rdAddrLog.size(), 4);
        for (int i = 0; i < 4 && i < rdAddrLog.size(); i++) begin
            check("read_addr", rdAddrLog[i], {la, i[1:0], 2'b00});
        end
        @(negedge clk);
        check("done_pulse", done, 1'b0);
        check("ready_after_done", req_ready, 1'b1);
        check("line_held", lineData, expLine);
    endtask

    task automatic runMiss(input logic [27:0] la, input logic dirty, input logic [27:0] va,
                           input logic [127:0] vd, input int expLat, input logic holdValid);
        int t0;
        startMiss(la, dirty, va, vd, t0);
        finishMiss(la, dirty, va, vd, t0, expLat, holdValid);
    endtask

    initial begin
        logic [127:0] heldLine;
        int           t0;
        int           n;

        // reset state
        rest           = 1'b1;
        req_valid      = 1'b0;
        req_lineAddr   = '0;
        req_dirty      = 1'b0;
        req_victimAddr = '0;
        req_victimData = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_cmd", {m0_read, m0_write, done}, 3'b000);
        check("rst_address", m0_address, 32'h0);
        check("rst_wdata", m0_writeData, 32'h0);
        check("rst_line", lineData, 128'h0);
        rest = 1'b0;
        #1;
        check("ready_after_rst", req_ready, 1'b1);
        @(negedge clk);

        // clean miss, 1-cycle latency, known data
        memInit[32'h0000_1230] = 32'hA0;
        memInit[32'h0000_1234] = 32'hA1;
        memInit[32'h0000_1238] = 32'hA2;
        memInit[32'h0000_123C] = 32'hA3;
        runMiss(28'h0000123, 1'b0, 28'h0, 128'h0, 6, 1'b0);
        check("clean_line_literal", lineData, 128'h000000A3_000000A2_000000A1_000000A0);

        // dirty miss: four writes first, reads only afterwards
        runMiss(28'h0000123, 1'b1, 28'h0000040,
                {32'd4, 32'd3, 32'd2, 32'd1}, 10, 1'b0);

        // three-cycle stall on the second read
        stallOnRead = 1;
        stallLeft   = 3;
        runMiss(28'h0000123, 1'b0, 28'h0, 128'h0, 9, 1'b0);
        check("stall_addr_cycles", presentedAt1234, 4);
        stallOnRead = -1;

        // long read latency: all reads in flight before the first return
        latency = 6;
        runMiss(28'h0ABCDE1, 1'b0, 28'h0, 128'h0, 11, 1'b0);
        check("max_outstanding", maxOutst, MaxOut);
        latency = 1;

        // reset after two of four beats have returned
        startMiss(28'h0555555, 1'b0, 28'h0, 128'h0, t0);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (retDriven < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("two_beats_returned", retDriven, 2);
        rest = 1'b1;
        @(negedge clk);
        rest = 1'b0;
        #1;
        check("midrst_read", m0_read, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_ready", req_ready, 1'b1);
        @(negedge clk);
        runMiss(28'h0000123, 1'b0, 28'h0, 128'h0, 6, 1'b0);
        check("post_rst_line", lineData, 128'h000000A3_000000A2_000000A1_000000A0);

        // req_valid held with changing fields while busy, then a stray beat in IDLE
        runMiss(28'h0123456, 1'b1, 28'h0FEDCBA,
                {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444}, 10, 1'b1);
        heldLine = lineData;
        strayBeat = 1'b1;
        repeat (4) @(negedge clk);
        check("no_extra_reads", rdAcceptCount, 4);
        check("stray_done", done, 1'b0);
        check("stray_line", lineData, heldLine);
        check("stray_ready", req_ready, 1'b1);

        // randomized misses with random latency and stalls
        for (int k = 0; k < 20; k++) begin
            logic [27:0]  la;
            logic [27:0]  va;
            logic [127:0] vd;
            logic         dirty;
            memSalt  = $urandom;
            latency  = int'($urandom_range(5, 1));
            stallPct = int'($urandom_range(40));
            la       = 28'($urandom);
            va       = 28'($urandom);
            vd       = {$urandom, $urandom, $urandom, $urandom};
            dirty    = 1'($urandom);
            runMiss(la, dirty, va, vd, -1, 1'($urandom));
        end
        stallPct = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
